// File: rtl/bcd_seq_pkg.sv
// Shared types and bit positions for the 3-digit BCD count sequencer.
package bcd_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int SW_RUN = 0;
    localparam int SW_DIR = 1;
    localparam int SW_CLR = 2;
    localparam int SW_FRZ = 3;

    localparam int LED_RUN   = 0;
    localparam int LED_DIR   = 1;
    localparam int LED_WRAP  = 2;
    localparam int LED_ACK   = 3;
    localparam int LED_ST_LO = 4;
    localparam int LED_ST_HI = 5;
    localparam int LED_HB    = 6;
    localparam int LED_FRZ   = 7;

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit with up/down stepping; cells chain through carry/borrow.
module bcd_digit_cell
    import bcd_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       step,
    input  logic       down,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    bcd_t digit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
        end else if (clr) begin
            digit_q <= '0;
        end else if (step && cin) begin
            if (down) begin
                digit_q <= (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
            end else begin
                digit_q <= (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
            end
        end
    end

    // Carry (up) or borrow (down) ripples only when this digit rolls over.
    assign cout  = cin & (down ? (digit_q == 4'd0) : (digit_q == 4'd9));
    assign digit = digit_q;

endmodule

// File: rtl/bcd_count_sequencer.sv
// Switch-driven 3-digit BCD up/down counter with snapshot handshake and status LEDs.
module bcd_count_sequencer
    import bcd_seq_pkg::*;
#(
    parameter int TICK_DIV    = 5_000_000,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic [3:0] switcher_i,
    input  logic       snap_req_i,
    output logic       snap_ack_o,
    output logic [3:0] unites_o,
    output logic [3:0] dizaines_o,
    output logic [3:0] centaines_o,
    output logic       wrap_o,
    output logic [7:0] led_o
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [1:0]                  rst_sync;
    logic                        rst_n;
    logic [SYNC_STAGES-1:0][3:0] sync_q;
    logic [3:0]                  sw;
    logic                        run, dir, frz, clr_edge, clr_prev;
    logic [PW-1:0]               presc_q;
    logic                        presc_last, tick, step;
    state_t                      state_q, state_d;
    bcd_t                        units_d, tens_d, hund_d;
    logic                        c0, c1, c2, wrap_evt;
    logic                        wrap_q, sticky_q, hb_q, req_q, ack_q, hold;

    // Reset asserts asynchronously but is released in step with the clock.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_n = rst_sync[1];

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            clr_prev <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], switcher_i};
            clr_prev <= sw[SW_CLR];
        end
    end

    assign sw       = sync_q[SYNC_STAGES-1];
    assign run      = sw[SW_RUN];
    assign dir      = sw[SW_DIR];
    assign frz      = sw[SW_FRZ];
    assign clr_edge = sw[SW_CLR] & ~clr_prev;

    assign presc_last = (presc_q == PW'(TICK_DIV - 1));
    assign tick       = (state_q == S_RUN) && presc_last;
    assign step       = tick & ~clr_edge;

    // Prescaler is frozen outside S_RUN so a pause keeps the tick phase.
    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else if (clr_edge) begin
            presc_q <= '0;
        end else if (state_q == S_RUN) begin
            presc_q <= presc_last ? '0 : presc_q + 1'b1;
        end
    end

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clr_edge) begin
            state_d = run ? S_RUN : S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (run)  state_d = S_RUN;
                S_RUN:   if (!run) state_d = S_PAUSE;
                S_PAUSE: if (run)  state_d = S_RUN;
                default: state_d = S_IDLE;
            endcase
        end
    end

    bcd_digit_cell u_unites (
        .clk(clk_clk), .rst_n(rst_n), .clr(clr_edge), .step(step), .down(dir),
        .cin(1'b1), .digit(units_d), .cout(c0)
    );
    bcd_digit_cell u_dizaines (
        .clk(clk_clk), .rst_n(rst_n), .clr(clr_edge), .step(step), .down(dir),
        .cin(c0), .digit(tens_d), .cout(c1)
    );
    bcd_digit_cell u_centaines (
        .clk(clk_clk), .rst_n(rst_n), .clr(clr_edge), .step(step), .down(dir),
        .cin(c1), .digit(hund_d), .cout(c2)
    );

    assign wrap_evt = step & c2;

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
            hb_q     <= 1'b0;
        end else begin
            wrap_q   <= wrap_evt;
            sticky_q <= clr_edge ? 1'b0 : (sticky_q | wrap_evt);
            hb_q     <= hb_q ^ tick;
        end
    end

    // req_q also holds the outputs on the cycle before ack rises, so the
    // snapshot keeps the value loaded on the request edge.
    assign hold = frz | req_q | ack_q;

    always_ff @(posedge clk_clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q       <= 1'b0;
            ack_q       <= 1'b0;
            unites_o    <= '0;
            dizaines_o  <= '0;
            centaines_o <= '0;
        end else begin
            req_q <= snap_req_i;
            ack_q <= req_q & snap_req_i;
            if (!hold) begin
                unites_o    <= units_d;
                dizaines_o  <= tens_d;
                centaines_o <= hund_d;
            end
        end
    end

    assign snap_ack_o = ack_q;
    assign wrap_o     = wrap_q;

    always_comb begin
        led_o                       = '0;
        led_o[LED_RUN]              = (state_q == S_RUN);
        led_o[LED_DIR]              = dir;
        led_o[LED_WRAP]             = sticky_q;
        led_o[LED_ACK]              = ack_q;
        led_o[LED_ST_HI:LED_ST_LO]  = state_q;
        led_o[LED_HB]               = hb_q;
        led_o[LED_FRZ]              = frz;
    end

endmodule

// File: tb/tb_bcd_count_sequencer.sv
// Scoreboard bench: integer-count reference model feeds a queue, a negedge monitor compares.
module tb_bcd_count_sequencer;

    localparam int TICK_DIV    = 4;
    localparam int SYNC_STAGES = 2;
    localparam int MODE_IDLE   = 0;
    localparam int MODE_RUN    = 1;
    localparam int MODE_PAUSE  = 2;
    localparam logic [3:0] B_RUN = 4'b0001;
    localparam logic [3:0] B_DIR = 4'b0010;
    localparam logic [3:0] B_CLR = 4'b0100;
    localparam logic [3:0] B_FRZ = 4'b1000;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       req;
    logic       ack;
    logic [3:0] unites, dizaines, centaines;
    logic       wrap;
    logic [7:0] led;

    typedef struct {
        int         val;
        logic       wrap;
        logic       ack;
        logic [7:0] led;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   wrap_seen = 0;

    logic [3:0] m_syn [SYNC_STAGES];
    logic       m_clr_prev, m_wrap, m_sticky, m_hb, m_req_q, m_ack;
    int         m_mode, m_phase, m_cnt, m_out, m_rel;

    bcd_count_sequencer #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .switcher_i    (sw),
        .snap_req_i    (req),
        .snap_ack_o    (ack),
        .unites_o      (unites),
        .dizaines_o    (dizaines),
        .centaines_o   (centaines),
        .wrap_o        (wrap),
        .led_o         (led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [11:0] bcd3(input int v);
        bcd3 = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t make_rec();
        exp_t r;
        logic [3:0] s;
        s      = m_syn[SYNC_STAGES-1];
        r.val  = m_out;
        r.wrap = m_wrap;
        r.ack  = m_ack;
        r.led  = {s[3], m_hb, 2'(m_mode), m_ack, m_sticky, s[1], (m_mode == MODE_RUN)};
        return r;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < SYNC_STAGES; k++) m_syn[k] = '0;
        m_clr_prev = 0; m_wrap = 0; m_sticky = 0; m_hb = 0; m_req_q = 0; m_ack = 0;
        m_mode = MODE_IDLE; m_phase = 0; m_cnt = 0; m_out = 0;
    endtask

    // Count kept as a plain integer 0..999; the switches see a SYNC_STAGES delay line.
    task automatic model_step();
        logic [3:0] s;
        bit run, down, clr, frz, tick, wrap_now;
        s    = m_syn[SYNC_STAGES-1];
        run  = s[0]; down = s[1]; frz = s[3];
        clr  = s[2] && !m_clr_prev;
        tick = (m_mode == MODE_RUN) && (m_phase == TICK_DIV - 1);
        wrap_now = tick && !clr && ((down && m_cnt == 0) || (!down && m_cnt == 999));
        if (!(frz || m_req_q || m_ack)) m_out = m_cnt;
        m_ack   = m_req_q && req;
        m_req_q = req;
        if (clr) begin
            m_cnt = 0; m_phase = 0; m_sticky = 0;
        end else begin
            if (tick) m_cnt = down ? (m_cnt + 999) % 1000 : (m_cnt + 1) % 1000;
            if (m_mode == MODE_RUN) m_phase = (m_phase + 1) % TICK_DIV;
            if (wrap_now) m_sticky = 1;
        end
        m_wrap = wrap_now;
        if (tick) m_hb = !m_hb;
        if (run) m_mode = MODE_RUN;
        else if (clr || m_mode == MODE_IDLE) m_mode = MODE_IDLE;
        else m_mode = MODE_PAUSE;
        m_clr_prev = s[2];
        for (int k = SYNC_STAGES - 1; k > 0; k--) m_syn[k] = m_syn[k-1];
        m_syn[0] = sw;
        sb.push_back(make_rec());
    endtask

    // Two edges after reset release the design is still held by its reset synchroniser.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
            sb.delete();
            m_rel = 0;
        end else if (m_rel < 2) begin
            m_rel++;
            sb.push_back(make_rec());
        end else begin
            model_step();
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (wrap === 1'b1) wrap_seen++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_output("sb_digits", {20'd0, centaines, dizaines, unites}, {20'd0, bcd3(e.val)});
            check_output("sb_wrap", {31'd0, wrap}, {31'd0, e.wrap});
            check_output("sb_ack", {31'd0, ack}, {31'd0, e.ack});
            check_output("sb_led", {24'd0, led}, {24'd0, e.led});
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic [3:0] s, input logic r);
        sw  = s;
        req = r;
    endtask

    task automatic wait_cnt(input int target, input int budget, input string name);
        for (int i = 0; i < budget; i++) begin
            if (m_cnt == target) break;
            step(1);
        end
        if (m_cnt != target) check_output(name, m_cnt, target);
    endtask

    task automatic check_digits(input string name, input logic [11:0] exp);
        check_output(name, {20'd0, centaines, dizaines, unites}, {20'd0, exp});
    endtask

    task automatic check_all_zero(input string name);
        check_digits({name, "_digits"}, 12'h000);
        check_output({name, "_ack"}, {31'd0, ack}, 32'd0);
        check_output({name, "_wrap"}, {31'd0, wrap}, 32'd0);
        check_output({name, "_led"}, {24'd0, led}, 32'd0);
    endtask

    initial begin
        int w0;
        int tgt;
        logic [3:0] s;
        logic r;
        rst_n = 1'b1;
        apply_stimulus(4'b0000, 1'b0);
        #2 rst_n = 1'b0;
        step(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        step(3);

        // Count up from reset
        apply_stimulus(B_RUN, 1'b0);
        wait_cnt(40, 400, "t1_reach");
        step(2);
        check_digits("t1_digits_040", 12'h040);
        check_output("t1_state_run", {30'd0, led[5:4]}, 32'd1);
        check_output("t1_no_wrap", wrap_seen, 0);

        // Up wrap 999 -> 000
        wait_cnt(999, 4200, "t2_reach_999");
        step(2);
        check_digits("t2_digits_999", 12'h999);
        w0 = wrap_seen;
        wait_cnt(0, 20, "t2_reach_000");
        step(2);
        check_digits("t2_digits_000", 12'h000);
        check_output("t2_wrap_once", wrap_seen - w0, 1);
        step(5);
        check_output("t2_sticky", {31'd0, led[2]}, 32'd1);

        // Clear, then count down through 000 -> 999
        apply_stimulus(B_RUN | B_DIR | B_CLR, 1'b0);
        step(4);
        check_output("t3_sticky_cleared", {31'd0, led[2]}, 32'd0);
        check_digits("t3_cleared", 12'h000);
        apply_stimulus(B_RUN | B_DIR, 1'b0);
        w0 = wrap_seen;
        wait_cnt(999, 20, "t3_reach_999");
        step(2);
        check_digits("t3_digits_999", 12'h999);
        check_output("t3_wrap_once", wrap_seen - w0, 1);
        check_output("t3_dir_led", {31'd0, led[1]}, 32'd1);
        wait_cnt(998, 20, "t3_reach_998");
        step(2);
        check_digits("t3_digits_998", 12'h998);

        // Pause keeps the tick phase
        apply_stimulus(B_RUN | B_CLR, 1'b0);
        step(4);
        apply_stimulus(B_RUN, 1'b0);
        wait_cnt(123, 700, "t4_reach_123");
        apply_stimulus(4'b0000, 1'b0);
        step(4);
        check_output("t4_state_pause", {30'd0, led[5:4]}, 32'd2);
        step(16);
        apply_stimulus(B_RUN, 1'b0);
        step(4);
        check_digits("t4_before_tick", 12'h123);
        step(1);
        check_digits("t4_after_tick", 12'h124);

        // Snapshot handshake
        apply_stimulus(B_RUN | B_CLR, 1'b0);
        step(4);
        apply_stimulus(B_RUN, 1'b0);
        wait_cnt(50, 300, "t5_reach_050");
        apply_stimulus(B_RUN, 1'b1);
        step(1);
        check_output("t5_ack_not_yet", {31'd0, ack}, 32'd0);
        step(1);
        check_output("t5_ack_rise", {31'd0, ack}, 32'd1);
        check_digits("t5_snap_050", 12'h050);
        wait_cnt(53, 20, "t5_reach_053");
        check_digits("t5_still_050", 12'h050);
        apply_stimulus(B_RUN, 1'b0);
        step(1);
        check_output("t5_ack_fall", {31'd0, ack}, 32'd0);
        step(2);
        check_digits("t5_resume_053", 12'h053);

        // Clear edge landing on the same cycle as a tick
        wait_cnt(77, 200, "t6_reach_077");
        tgt = TICK_DIV - 1 - SYNC_STAGES;
        while (tgt < 0) tgt += TICK_DIV;
        for (int i = 0; i < TICK_DIV; i++) begin
            if (m_phase == tgt) break;
            step(1);
        end
        w0 = wrap_seen;
        apply_stimulus(B_RUN | B_CLR, 1'b0);
        step(3);
        check_output("t6_no_wrap_now", {31'd0, wrap}, 32'd0);
        check_output("t6_state_run", {30'd0, led[5:4]}, 32'd1);
        step(1);
        check_digits("t6_cleared", 12'h000);
        step(4);
        check_digits("t6_restart_001", 12'h001);
        check_output("t6_no_wrap", wrap_seen - w0, 0);
        apply_stimulus(B_RUN, 1'b0);

        // Reset in the middle of a snapshot
        apply_stimulus(B_RUN, 1'b1);
        step(3);
        check_output("t7_ack_before_reset", {31'd0, ack}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_all_zero("t7_async_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        apply_stimulus(B_RUN, 1'b0);
        step(3);

        // Randomised switch and request activity
        s = B_RUN;
        r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) s[0] = ~s[0];
            if ($urandom_range(0, 39) == 0) s[1] = ~s[1];
            if ($urandom_range(0, 49) == 0) s[2] = ~s[2];
            if ($urandom_range(0, 59) == 0) s[3] = ~s[3];
            if ($urandom_range(0, 14) == 0) r = ~r;
            apply_stimulus(s, r);
            step(1);
            if (i == 1700) begin
                @(posedge clk);
                #3 rst_n = 1'b0;
                #1 check_all_zero("rand_reset");
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end
        step(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
